// File: rtl/mul_issue_ctrl.sv
// Valid/ready issue controller for the iterative Booth multiplier datapath, with a hold register
// and an output register. Optional zero-operand bypass is enabled by defining MUL_ZERO_BYPASS_EN.
module mul_issue_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_a,
  input  logic [WIDTH-1:0]     s_b,
  input  logic [TAG_W-1:0]     s_tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH-1:0]   m_product,
  output logic [TAG_W-1:0]     m_tag,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBusy,
    StCapt,
    StHold
  } state_e;

  state_e               state_q;
  logic                 s_ready_q;
  logic                 mul_start_q;
  logic [WIDTH-1:0]     mul_a_q;
  logic [WIDTH-1:0]     mul_b_q;
  logic [TAG_W-1:0]     tag_q;
  logic [2*WIDTH-1:0]   hold_prod_q;
  logic [TAG_W-1:0]     hold_tag_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   out_prod_q;
  logic [TAG_W-1:0]     out_tag_q;
  logic                 err_q;

  logic                 out_pop;
  logic                 done_err;
  logic [2*WIDTH-1:0]   capt_prod;

  assign out_pop = out_valid_q && m_ready;

  // mul_done is only legal while waiting in BUSY, and never alongside the start pulse.
  assign done_err = mul_done && ((state_q != StBusy) || mul_start_q);

`ifdef MUL_ZERO_BYPASS_EN
  logic zero_q;
  logic zero_in;

  assign zero_in   = (s_a == '0) || (s_b == '0);
  assign capt_prod = zero_q ? '0 : mul_product;
`else
  assign capt_prod = mul_product;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      s_ready_q   <= 1'b1;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_q       <= '0;
      hold_prod_q <= '0;
      hold_tag_q  <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      out_tag_q   <= '0;
      err_q       <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      mul_start_q <= 1'b0;
      if (out_pop) begin
        out_valid_q <= 1'b0;
      end
      if (done_err) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (s_valid) begin
            mul_a_q   <= s_a;
            mul_b_q   <= s_b;
            tag_q     <= s_tag;
            s_ready_q <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
            zero_q    <= zero_in;
            if (zero_in) begin
              state_q <= StCapt;
            end else begin
              state_q     <= StStart;
              mul_start_q <= 1'b1;
            end
`else
            state_q     <= StStart;
            mul_start_q <= 1'b1;
`endif
          end
        end

        StStart: begin
          state_q <= StBusy;
        end

        StBusy: begin
          if (mul_done) begin
            state_q <= StCapt;
          end
        end

        StCapt: begin
          // The output register is free if empty or being drained on this very edge.
          if (!out_valid_q || m_ready) begin
            out_prod_q  <= capt_prod;
            out_tag_q   <= tag_q;
            out_valid_q <= 1'b1;
            s_ready_q   <= 1'b1;
            state_q     <= StIdle;
          end else begin
            hold_prod_q <= capt_prod;
            hold_tag_q  <= tag_q;
            state_q     <= StHold;
          end
        end

        StHold: begin
          if (out_pop) begin
            out_prod_q  <= hold_prod_q;
            out_tag_q   <= hold_tag_q;
            out_valid_q <= 1'b1;
            s_ready_q   <= 1'b1;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q   <= StIdle;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign m_valid   = out_valid_q;
  assign m_product = out_prod_q;
  assign m_tag     = out_tag_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: behavioural datapath model, result monitor and
// per-scenario tasks comparing observed results against products computed from the requests.
module tb_mul_issue_ctrl;

  localparam int W  = 16;
  localparam int TW = 4;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [TW-1:0]  t;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [W-1:0]    s_a = '0;
  logic [W-1:0]    s_b = '0;
  logic [TW-1:0]   s_tag = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [2*W-1:0]  m_product;
  logic [TW-1:0]   m_tag;
  logic            mul_start;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic            mul_done = 1'b0;
  logic [2*W-1:0]  mul_product = '0;
  logic            err_o;

  int checks = 0;
  int errors = 0;

  mul_issue_ctrl #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_a         (s_a),
    .s_b         (s_b),
    .s_tag       (s_tag),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_product   (m_product),
    .m_tag       (m_tag),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Result sink: random or forced ready, changed just after each rising edge.
  bit rdy_rand  = 1'b0;
  bit rdy_force = 1'b1;
  always @(posedge clk) begin
    #1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Datapath model: done after dp_lat cycles, product valid only the cycle after done.
  int             dp_lat = 3;
  bit             dp_rand = 1'b0;
  int             start_cnt = 0;
  int             stray_req = 0;
  int             stray_ack = 0;
  int             dp_cnt = 0;
  bit             done_prev = 1'b0;
  logic [2*W-1:0] pend = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      dp_cnt    = 0;
      mul_done  = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) begin
        mul_product = pend;
        done_prev   = 1'b0;
      end
      mul_done = 1'b0;
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          mul_done    = 1'b1;
          done_prev   = 1'b1;
          mul_product = {$urandom, $urandom};
        end
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        mul_done  = 1'b1;
      end
      if (mul_start) begin
        start_cnt++;
        dp_cnt = dp_rand ? $urandom_range(1, 6) : dp_lat;
        pend   = $signed(mul_a) * $signed(mul_b);
      end
    end
  end

  // Monitor: records output handshakes, stall-stability violations and handshake cycles.
  res_t obs_q[$];
  int   cyc = 0;
  int   stall_viol = 0;
  int   last_acc = 0;
  int   last_obs = 0;
  bit   prev_stall = 1'b0;
  res_t prev_res;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_product !== prev_res.p || m_tag !== prev_res.t)) begin
        stall_viol++;
      end
      if (m_valid && m_ready) begin
        obs_q.push_back('{p: m_product, t: m_tag});
        last_obs = cyc;
      end
      if (s_valid && s_ready) last_acc = cyc;
      prev_stall = m_valid && !m_ready;
      prev_res   = '{p: m_product, t: m_tag};
    end
  end

  res_t exp_q[$];
  int   rd_idx = 0;

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
    bit done;
    done    = 1'b0;
    s_a     = a;
    s_b     = b;
    s_tag   = tag;
    s_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: request tag %0d not accepted, required accept within 500 cycles",
               tag);
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    int i;
    for (i = 0; i < budget && obs_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL result_timeout: got %0d results, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare every outstanding expected result against what the monitor has recorded.
  task automatic drain_compare(input string name);
    while (exp_q.size() > 0) begin
      res_t e;
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++;
        $display("FAIL %s_missing: no result, required product %h tag %0d", name, e.p, e.t);
      end else begin
        if (obs_q[rd_idx].p !== e.p || obs_q[rd_idx].t !== e.t) begin
          errors++;
          $display("FAIL %s: got product %h tag %0d, required product %h tag %0d", name,
                   obs_q[rd_idx].p, obs_q[rd_idx].t, e.p, e.t);
        end
        rd_idx++;
      end
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
    logic [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    exp_q.push_back('{p: p, t: t});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err_o); end
    if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b, required 0", mul_start); end
    if (m_product !== '0) begin errors++; $display("FAIL reset_product: got %h, required 0", m_product); end
    if (mul_a !== '0) begin errors++; $display("FAIL reset_mul_a: got %h, required 0", mul_a); end
  endtask

  task automatic test_basic();
    int s0;
    int lat;
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    dp_rand   = 1'b0;
    dp_lat    = 3;
    idle_cycles(1);
    s0 = start_cnt;
    send(16'd3, -16'sd5, 4'd2);
    exp_q.push_back('{p: 32'hFFFF_FFF1, t: 4'd2});
    wait_obs(rd_idx + 1, 100);
    drain_compare("basic_result");
    idle_cycles(4);
    checks += 2;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL basic_start_pulses: got %0d, required 1", start_cnt - s0);
    end
    lat = last_obs - last_acc;
    if (lat != dp_lat + 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, dp_lat + 3);
    end
  endtask

  task automatic test_corners();
    send(16'h8000, 16'h8000, 4'd5);
    exp_q.push_back('{p: 32'h4000_0000, t: 4'd5});
    send(16'h7FFF, 16'h8000, 4'd6);
    exp_q.push_back('{p: 32'hC000_8000, t: 4'd6});
    wait_obs(rd_idx + 2, 100);
    drain_compare("corner_result");
  endtask

  task automatic test_random();
    int base;
    logic [W-1:0] a;
    logic [W-1:0] b;
    base     = rd_idx;
    rdy_rand = 1'b1;
    dp_rand  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 6 == 1) a = '0;
      if (i % 6 == 3) b = 16'h8000;
      if (i % 6 == 4) a = 16'h7FFF;
      push_exp(a, b, TW'(i));
      send(a, b, TW'(i));
    end
    wait_obs(base + 24, 3000);
    drain_compare("random_result");
    rdy_rand = 1'b0;
    dp_rand  = 1'b0;
    idle_cycles(2);
    checks += 2;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL random_stall_stability: got %0d violations, required 0", stall_viol);
    end
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL random_err: got %b, required 0", err_o);
    end
  endtask

  task automatic test_back_to_back();
    int ready_seen;
    rdy_force = 1'b0;
    idle_cycles(2);
    push_exp(16'd11, 16'd13, 4'd1);
    send(16'd11, 16'd13, 4'd1);
    push_exp(-16'sd9, 16'd21, 4'd2);
    send(-16'sd9, 16'd21, 4'd2);
    idle_cycles(dp_lat + 6);
    checks += 3;
    if (m_valid !== 1'b1 || m_tag !== 4'd1) begin
      errors++;
      $display("FAIL b2b_output_held: got valid %b tag %0d, required valid 1 tag 1", m_valid, m_tag);
    end
    if (m_product !== 32'd143) begin
      errors++;
      $display("FAIL b2b_output_product: got %h, required %h", m_product, 32'd143);
    end
    // A third request must not be taken while op2 sits in the hold register.
    s_a        = 16'd4;
    s_b        = 16'd4;
    s_tag      = 4'd3;
    s_valid    = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_ready) ready_seen++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (ready_seen != 0) begin
      errors++;
      $display("FAIL b2b_s_ready_blocked: got ready on %0d cycles, required 0", ready_seen);
    end
    rdy_force = 1'b1;
    wait_obs(rd_idx + 2, 100);
    drain_compare("b2b_order");
    push_exp(16'd4, 16'd4, 4'd3);
    send(16'd4, 16'd4, 4'd3);
    wait_obs(rd_idx + 1, 100);
    drain_compare("b2b_after");
  endtask

  task automatic test_stray_done();
    idle_cycles(2);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL stray_pre_err: got %b, required 0", err_o); end
    stray_req++;
    idle_cycles(3);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL stray_err_set: got %b, required 1", err_o); end
    push_exp(16'd5, 16'd6, 4'd7);
    send(16'd5, 16'd6, 4'd7);
    wait_obs(rd_idx + 1, 100);
    drain_compare("stray_followup");
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL stray_err_sticky: got %b, required 1", err_o); end
    do_reset();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL stray_err_cleared: got %b, required 0", err_o); end
  endtask

  task automatic test_reset_mid();
    int n0;
    dp_lat = 8;
    send(16'd100, 16'd100, 4'd9);
    idle_cycles(3);
    n0 = obs_q.size();
    rst_n = 1'b0;
    idle_cycles(2);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_m_valid: got %b, required 0", m_valid); end
    rst_n  = 1'b1;
    dp_lat = 3;
    idle_cycles(1);
    push_exp(16'd2, 16'd7, 4'd3);
    send(16'd2, 16'd7, 4'd3);
    wait_obs(n0 + 1, 100);
    idle_cycles(12);
    checks++;
    if (obs_q.size() != n0 + 1) begin
      errors++;
      $display("FAIL midreset_result_count: got %0d, required %0d", obs_q.size() - n0, 1);
    end
    rd_idx = n0;
    drain_compare("midreset_result");
    rd_idx = obs_q.size();
  endtask

  task automatic test_zero();
    int s0;
    int lat;
    int exp_starts;
    int exp_lat;
`ifdef MUL_ZERO_BYPASS_EN
    exp_starts = 0;
    exp_lat    = 2;
`else
    exp_starts = 1;
    exp_lat    = dp_lat + 3;
`endif
    s0 = start_cnt;
    exp_q.push_back('{p: 32'h0, t: 4'd12});
    send(16'd0, 16'd123, 4'd12);
    wait_obs(rd_idx + 1, 100);
    drain_compare("zero_result");
    idle_cycles(4);
    checks += 2;
    if (start_cnt - s0 != exp_starts) begin
      errors++;
      $display("FAIL zero_start_pulses: got %0d, required %0d", start_cnt - s0, exp_starts);
    end
    lat = last_obs - last_acc;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL zero_latency: got %0d, required %0d", lat, exp_lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_zero();
    test_stray_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
